// File: rtl/bit_count_pkg.sv
// rtl/bit_count_pkg.sv - shared types and defaults for the serial bit counter
package bit_count_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} bc_state_t;
  typedef enum logic {MODE_ONES, MODE_LZ} bc_mode_t;

  localparam int DEFAULT_DATA_W = 8;

endpackage

// File: rtl/bc_shift_reg.sv
// rtl/bc_shift_reg.sv - MSB-first shift register with zero detect for bit_count_unit
module bc_shift_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] data_in,
  output logic              msb,
  output logic              is_zero
);

  logic [DATA_W-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= data_in;
    end else if (shift_en) begin
      sr <= {sr[DATA_W-2:0], 1'b0};
    end
  end

  assign msb     = sr[DATA_W-1];
  assign is_zero = (sr == '0);

endmodule

// File: rtl/bit_count_unit.sv
// rtl/bit_count_unit.sv - self-sequenced ones / leading-zero counter with start/ready/done handshake
// Optional macro EARLY_EXIT_EN: finish as soon as the remaining shift contents are zero.
module bit_count_unit
  import bit_count_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              done,
  output logic [CNT_W-1:0]  result,
  output logic              all_zero
);

`ifdef EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DATA_W);

  bc_state_t        state, state_nxt;
  bc_mode_t         mode_q;
  logic [CNT_W-1:0] count, count_nxt, bits_left;
  logic             accept, finish, sr_msb, sr_zero, early_hit;

  bc_shift_reg #(.DATA_W(DATA_W)) u_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .shift_en (state == SHIFT),
    .data_in  (data_in),
    .msb      (sr_msb),
    .is_zero  (sr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)  state_nxt = SHIFT;
      SHIFT:   if (finish) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
    done  = (state == DONE);
  end

  assign accept    = ready & start;
  assign early_hit = EARLY_EXIT & sr_zero;

  // LZ stops on the first set MSB without counting it; an early exit in LZ credits the unshifted zeros.
  always_comb begin
    count_nxt = count;
    finish    = 1'b0;
    if (state == SHIFT) begin
      if (early_hit) begin
        finish = 1'b1;
        if (mode_q == MODE_LZ) count_nxt = count + bits_left;
      end else if (mode_q == MODE_LZ && sr_msb) begin
        finish = 1'b1;
      end else begin
        count_nxt = count + ((mode_q == MODE_ONES) ? CNT_W'(sr_msb) : CNT_W'(1));
        finish    = (bits_left == CNT_W'(1));
      end
    end
  end

  // An all-zero operand is the only way to end with zero ones or with a full leading-zero count.
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      bits_left <= '0;
      mode_q    <= MODE_ONES;
      result    <= '0;
      all_zero  <= 1'b0;
    end else begin
      if (accept) begin
        count     <= '0;
        bits_left <= FULL;
        mode_q    <= bc_mode_t'(mode);
      end else if (state == SHIFT) begin
        count     <= count_nxt;
        bits_left <= bits_left - CNT_W'(1);
      end
      if (finish) begin
        result   <= count_nxt;
        all_zero <= (mode_q == MODE_ONES) ? (count_nxt == '0) : (count_nxt == FULL);
      end
    end
  end

endmodule
